// File: rtl/traffic_pkg.sv
// Shared state encoding and sizing helper for the N-phase traffic-light controller.
// Pure declarations: no logic, no latency, no flow control.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    // Width of a phase index; at least one bit so a 1-entry index is still legal.
    function automatic int phase_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_phase.sv
// Combinational round-robin picker: first requester after the active phase, with wrap.
// Zero latency; no flow control, result is valid whenever inputs are.
module rr_next_phase #(
    parameter int NUM_PHASES = 4,
    parameter int PW         = 2
) (
    input  logic [NUM_PHASES-1:0] req,
    input  logic [PW-1:0]         active,
    output logic [PW-1:0]         nxt,
    output logic                  any_other
);

    logic [NUM_PHASES-1:0] others;
    logic                  found;
    int                    idx;

    always_comb begin
        others         = req;
        others[active] = 1'b0;
        any_other      = |others;
        // With no other requester the rotation simply steps to the neighbour.
        nxt   = PW'((int'(active) + 1) % NUM_PHASES);
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i < NUM_PHASES; i++) begin
            idx = (int'(active) + i) % NUM_PHASES;
            if (!found && others[idx]) begin
                nxt   = PW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-phase traffic-light controller: timed green/yellow/all-red, round-robin service, rest on green.
// Lamps update one clock after the deciding tick edge; tick=0 freezes all timing and outputs.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 8,
    parameter int GREEN_MIN   = 3,
    parameter int GREEN_MAX   = 6,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    localparam int PW         = phase_w(NUM_PHASES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] req,
    input  logic                  change,
    output logic [NUM_PHASES-1:0] redout,
    output logic [NUM_PHASES-1:0] yellowout,
    output logic [NUM_PHASES-1:0] greenout,
    output logic [PW-1:0]         active_phase,
    output logic                  phase_start
);

    localparam logic [CNT_W-1:0] GMIN_M1   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_TIME - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      elapsed;
    logic [PW-1:0]         next_phase;
    logic [PW-1:0]         pick_nxt;
    logic                  any_other;
    logic                  min_met;
    logic                  max_met;
    logic [NUM_PHASES-1:0] red_d;
    logic [NUM_PHASES-1:0] yellow_d;
    logic [NUM_PHASES-1:0] green_d;

    rr_next_phase #(
        .NUM_PHASES (NUM_PHASES),
        .PW         (PW)
    ) u_rr (
        .req        (req),
        .active     (active_phase),
        .nxt        (pick_nxt),
        .any_other  (any_other)
    );

    always_comb begin
        state_nxt = state;
        min_met   = (elapsed >= GMIN_M1);
        max_met   = (elapsed >= GMAX_M1);
        case (state)
            ST_ALLRED: if (tick && elapsed >= ALLRED_M1) state_nxt = ST_GREEN;
            ST_GREEN: begin
                if (tick && ((min_met && !req[active_phase] && any_other) ||
                             (max_met && any_other) ||
                             (min_met && change)))
                    state_nxt = ST_YELLOW;
            end
            ST_YELLOW: if (tick && elapsed >= YELLOW_M1) state_nxt = ST_ALLRED;
            default:   state_nxt = ST_ALLRED;
        endcase
    end

    // Lamps are decoded from the next state so the registered outputs track the state register.
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        case (state_nxt)
            ST_GREEN: begin
                green_d[active_phase] = 1'b1;
                red_d[active_phase]   = 1'b0;
            end
            ST_YELLOW: begin
                yellow_d[active_phase] = 1'b1;
                red_d[active_phase]    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_ALLRED;
            elapsed      <= '0;
            active_phase <= '0;
            next_phase   <= '0;
            redout       <= '1;
            yellowout    <= '0;
            greenout     <= '0;
            phase_start  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                elapsed <= '0;
            else if (tick && elapsed != '1)
                elapsed <= elapsed + CNT_W'(1);
            if (state == ST_GREEN && state_nxt == ST_YELLOW)
                next_phase <= pick_nxt;
            // During all-red the active index already announces the phase about to be served.
            if (state_nxt == ST_ALLRED)
                active_phase <= next_phase;
            redout      <= red_d;
            yellowout   <= yellow_d;
            greenout    <= green_d;
            phase_start <= (state == ST_ALLRED) && (state_nxt == ST_GREEN);
        end
    end

endmodule
